// File: rtl/sram_unit_pkg.sv
// Shared definitions for the dual-port SRAM unit: width-config encodings,
// the read-side tag carried alongside each request, and a lane-width helper.
package sram_unit_pkg;

    typedef enum logic [2:0] {
        CONF_X32 = 3'b000,
        CONF_X16 = 3'b001,
        CONF_X8  = 3'b010,
        CONF_X4  = 3'b011,
        CONF_X2  = 3'b100,
        CONF_X1  = 3'b101
    } conf_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] conf;
        logic [4:0] addr_lsb;
    } rd_tag_t;

    localparam int unsigned RD_TAG_W = $bits(rd_tag_t);

    // Encodings 110/111 behave as the 1-bit configuration.
    function automatic logic [5:0] lane_width(input logic [2:0] conf);
        logic [5:0] w;
        case (conf)
            CONF_X32: w = 6'd32;
            CONF_X16: w = 6'd16;
            CONF_X8:  w = 6'd8;
            CONF_X4:  w = 6'd4;
            CONF_X2:  w = 6'd2;
            default:  w = 6'd1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sel_pipe.sv
// Generic fixed-depth delay line with asynchronous active-low clear; shifts
// every cycle with no stall.
module sel_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = in_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/output_gather.sv
// Read-side field extractor: delays each request's width config and sub-word
// select to line up with SRAM read data, then registers the zero-extended field.
module output_gather
    import sram_unit_pkg::*;
#(
    parameter int unsigned SRAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  conf,
    input  logic [4:0]  addr_lsb,
    input  logic        rd_en,
    input  logic [31:0] sram_dout,
    output logic [31:0] dout,
    output logic        dout_valid
);

    if (SRAM_LAT < 1 || SRAM_LAT > 4) begin : g_bad_lat
        $error("output_gather: SRAM_LAT must be in 1..4");
    end

    rd_tag_t     head;
    rd_tag_t     tail;
    logic [31:0] dout_q;
    logic [31:0] dout_d;
    logic        dout_valid_q;
    logic        dout_valid_d;

    assign head = '{valid: rd_en, conf: conf, addr_lsb: addr_lsb};

    // Tail entry becomes visible in the same cycle its SRAM data is valid.
    sel_pipe #(
        .DEPTH (SRAM_LAT),
        .WIDTH (RD_TAG_W)
    ) u_sel_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (head),
        .out_o (tail)
    );

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = tail.valid;
        if (tail.valid) begin
            case (tail.conf)
                CONF_X32: dout_d = sram_dout;
                CONF_X16: dout_d = {16'b0, sram_dout[{tail.addr_lsb[0],   4'b0} +: 16]};
                CONF_X8:  dout_d = {24'b0, sram_dout[{tail.addr_lsb[1:0], 3'b0} +: 8]};
                CONF_X4:  dout_d = {28'b0, sram_dout[{tail.addr_lsb[2:0], 2'b0} +: 4]};
                CONF_X2:  dout_d = {30'b0, sram_dout[{tail.addr_lsb[3:0], 1'b0} +: 2]};
                default:  dout_d = {31'b0, sram_dout[tail.addr_lsb]};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= 32'h0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_output_gather.sv
// Drives two output_gather instances (SRAM_LAT 1 and 3) with directed and random
// reads, comparing against a queue-based arithmetic model of field extraction.
module tb_output_gather;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct {
        int          dut;
        int          due;
        logic [2:0]  cf;
        logic [4:0]  al;
        logic [31:0] val;
    } entry_t;

    logic        clk = 1'b0;
    logic        rstN      [2];
    logic [2:0]  confIn    [2];
    logic [4:0]  addrIn    [2];
    logic        rdEn      [2];
    logic [31:0] sramDout  [2];
    logic [31:0] doutOut   [2];
    logic        doutValid [2];

    bit          reqNext   [2];
    logic [2:0]  confNext  [2];
    logic [4:0]  addrNext  [2];
    bit          haveData  [2];
    logic [31:0] dataNext  [2];
    bit          rstNext   [2];
    logic [31:0] lastDout  [2];

    entry_t reqQ[$];
    entry_t expQ[$];
    int     cyc;
    int     checks;
    int     errors;

    always #5 clk = ~clk;

    output_gather #(.SRAM_LAT(LAT0)) dut0 (
        .clk        (clk),
        .rst_n      (rstN[0]),
        .conf       (confIn[0]),
        .addr_lsb   (addrIn[0]),
        .rd_en      (rdEn[0]),
        .sram_dout  (sramDout[0]),
        .dout       (doutOut[0]),
        .dout_valid (doutValid[0])
    );

    output_gather #(.SRAM_LAT(LAT1)) dut1 (
        .clk        (clk),
        .rst_n      (rstN[1]),
        .conf       (confIn[1]),
        .addr_lsb   (addrIn[1]),
        .rd_en      (rdEn[1]),
        .sram_dout  (sramDout[1]),
        .dout       (doutOut[1]),
        .dout_valid (doutValid[1])
    );

    function automatic int latOf(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    // Field width from the config, lane index from addr modulo lane count.
    function automatic logic [31:0] refField(input logic [2:0] cf, input logic [4:0] al,
                                             input logic [31:0] data);
        int w;
        int sel;
        logic [31:0] mask;
        w = (int'(cf) >= 5) ? 1 : (32 >> int'(cf));
        if (w == 32) return data;
        sel  = int'(al) % (32 / w);
        mask = (32'h1 << w) - 32'h1;
        return (data >> (sel * w)) & mask;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check registered outputs, then drive this cycle's inputs.
    task automatic applyStimulus();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            bit          found;
            logic [31:0] ev;
            found = 1'b0;
            ev    = lastDout[d];
            for (int i = 0; i < expQ.size(); i++) begin
                if (expQ[i].dut == d && expQ[i].due == cyc) begin
                    found = 1'b1;
                    ev    = expQ[i].val;
                    expQ.delete(i);
                    break;
                end
            end
            lastDout[d] = ev;
            checkOutput($sformatf("d%0d_valid_c%0d", d, cyc), {31'b0, doutValid[d]}, {31'b0, found});
            checkOutput($sformatf("d%0d_dout_c%0d", d, cyc), doutOut[d], ev);
        end
        for (int d = 0; d < 2; d++) begin
            bit matured;
            rstN[d]     = rstNext[d];
            sramDout[d] = $urandom;
            confIn[d]   = 3'($urandom_range(0, 7));
            addrIn[d]   = 5'($urandom_range(0, 31));
            if (!rstNext[d]) begin
                for (int i = reqQ.size() - 1; i >= 0; i--) if (reqQ[i].dut == d) reqQ.delete(i);
                for (int i = expQ.size() - 1; i >= 0; i--) if (expQ[i].dut == d) expQ.delete(i);
                lastDout[d] = 32'h0;
                rdEn[d]     = 1'b0;
            end else begin
                rdEn[d] = reqNext[d];
                if (reqNext[d]) begin
                    confIn[d] = confNext[d];
                    addrIn[d] = addrNext[d];
                    reqQ.push_back('{d, cyc + latOf(d), confNext[d], addrNext[d], 32'h0});
                end
                matured = 1'b0;
                for (int i = 0; i < reqQ.size() && !matured; i++) begin
                    if (reqQ[i].dut == d && reqQ[i].due == cyc) begin
                        matured = 1'b1;
                        if (haveData[d]) sramDout[d] = dataNext[d];
                        expQ.push_back('{d, cyc + 1, reqQ[i].cf, reqQ[i].al,
                                         refField(reqQ[i].cf, reqQ[i].al, sramDout[d])});
                        reqQ.delete(i);
                    end
                end
            end
            reqNext[d]  = 1'b0;
            haveData[d] = 1'b0;
        end
        cyc++;
    endtask

    task automatic setReq(input int d, input logic [2:0] cf, input logic [4:0] al);
        reqNext[d]  = 1'b1;
        confNext[d] = cf;
        addrNext[d] = al;
    endtask

    task automatic setData(input int d, input logic [31:0] v);
        haveData[d] = 1'b1;
        dataNext[d] = v;
    endtask

    task automatic runRead(input int d, input logic [2:0] cf, input logic [4:0] al,
                           input logic [31:0] data, input logic [31:0] expected, input string tag);
        setReq(d, cf, al);
        applyStimulus();
        repeat (latOf(d) - 1) applyStimulus();
        setData(d, data);
        applyStimulus();
        applyStimulus();
        checkOutput({tag, "_dout"}, doutOut[d], expected);
        checkOutput({tag, "_valid"}, {31'b0, doutValid[d]}, 32'h1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int d = 0; d < 2; d++) begin
            rstN[d]     = 1'b0;
            rstNext[d]  = 1'b0;
            confIn[d]   = 3'b0;
            addrIn[d]   = 5'b0;
            rdEn[d]     = 1'b0;
            sramDout[d] = 32'h0;
            reqNext[d]  = 1'b0;
            haveData[d] = 1'b0;
            confNext[d] = 3'b0;
            addrNext[d] = 5'b0;
            dataNext[d] = 32'h0;
            lastDout[d] = 32'h0;
        end

        repeat (3) applyStimulus();
        checkOutput("reset_dout", doutOut[0], 32'h0);
        checkOutput("reset_valid", {31'b0, doutValid[0]}, 32'h0);
        rstNext[0] = 1'b1;
        rstNext[1] = 1'b1;
        repeat (10) applyStimulus();

        runRead(0, 3'b000, 5'd17, 32'hDEADBEEF, 32'hDEADBEEF, "x32");
        runRead(0, 3'b010, 5'd2,  32'h11223344, 32'h00000022, "x8_lane2");
        runRead(0, 3'b101, 5'd31, 32'h80000000, 32'h00000001, "x1_bit31");

        setReq(0, 3'b000, 5'd0);
        applyStimulus();
        setReq(0, 3'b001, 5'd1);
        setData(0, 32'hA5A5F00D);
        applyStimulus();
        setReq(0, 3'b011, 5'd7);
        setData(0, 32'h12345678);
        applyStimulus();
        checkOutput("b2b_a", doutOut[0], 32'hA5A5F00D);
        setData(0, 32'h90000000);
        applyStimulus();
        checkOutput("b2b_b", doutOut[0], 32'h00001234);
        checkOutput("b2b_b_valid", {31'b0, doutValid[0]}, 32'h1);
        applyStimulus();
        checkOutput("b2b_c", doutOut[0], 32'h00000009);
        checkOutput("b2b_c_valid", {31'b0, doutValid[0]}, 32'h1);
        repeat (3) applyStimulus();

        setReq(1, 3'b000, 5'd0);
        applyStimulus();
        setReq(1, 3'b010, 5'd3);
        applyStimulus();
        applyStimulus();
        rstNext[1] = 1'b0;
        applyStimulus();
        rstNext[1] = 1'b1;
        repeat (8) applyStimulus();
        runRead(1, 3'b001, 5'd0, 32'hCAFE_BABE, 32'h0000BABE, "post_reset");
        repeat (4) applyStimulus();

        runRead(0, 3'b111, 5'd5, 32'h00000020, 32'h00000001, "illegal_conf");
        repeat (5) applyStimulus();
        checkOutput("hold_dout", doutOut[0], 32'h00000001);
        checkOutput("hold_valid", {31'b0, doutValid[0]}, 32'h0);

        for (int n = 0; n < 500; n++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 9) < 7) begin
                    setReq(d, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
                end
            end
            rstNext[1] = ($urandom_range(0, 79) != 0);
            applyStimulus();
        end
        rstNext[1] = 1'b1;
        repeat (LAT1 + 3) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
